mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Pipeline register and write-back logic directly downstream of the MEM stage. Each cycle it captures the MEM stage's forwarded control and result signals and, for loads, merges the synchronous RAM read data. It extracts and sign- or zero-extends the addressed byte or halfword, then drives the register-file write port and the WB forwarding path back to ID. Stall and flush come from the pipeline controller. Load data is held stable across multi-cycle stalls.

## Interface
- DATA_W, 32, data/result width (`DATA_BUS`)
- ADDR_W, 32, PC width (`ADDR_BUS`)
- REG_AW, 5, register address width (`REG_ADDR_BUS`)
- SEL_W, 4, byte-lane select width (`MEM_SEL_BUS`)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold WB register contents
- flush  in  1  replace WB contents with a bubble
- mem_read_flag_in  in  1  instruction in MEM is a load
- mem_write_flag_in  in  1  instruction in MEM is a store (registered, not used for write-back)
- mem_sign_ext_flag_in  in  1  sign-extend load data
- mem_sel_in  in  SEL_W  byte lanes of the access
- result_in  in  DATA_W  ALU result from MEM
- reg_write_en_in  in  1  register write enable from MEM
- reg_write_addr_in  in  REG_AW  destination register from MEM
- current_pc_addr_in  in  ADDR_W  PC from MEM
- ram_read_data  in  DATA_W  synchronous RAM data; valid the cycle after the load leaves MEM
- reg_write_en  out  1  register-file write enable
- reg_write_addr  out  REG_AW  register-file write address
- reg_write_data  out  DATA_W  register-file write data; also the WB forwarding value to ID

## Operation
- WB register fields: rd, wr, sx, sel, result, we, waddr, pc.
- Update rule, evaluated at each clk edge:
  - flush=1: clear all fields to 0. Flush wins over stall.
  - else stall=1: hold all fields.
  - else: load all fields from the *_in signals.
- Load-data holding register: `ld_hold` (DATA_W) plus flag `ld_valid`.
  - On an edge where WB holds a load (rd=1), stall=1 and ld_valid=0: `ld_hold`←ram_read_data, ld_valid←1.
  - Whenever the WB register loads new contents or flushes: ld_valid←0.
- Raw load word `lw_raw` = ld_valid ? ld_hold : ram_read_data.
- Extraction, little-endian, selected by sel:
  - 0001 / 0010 / 0100 / 1000: byte [7:0] / [15:8] / [23:16] / [31:24].
  - 0011 / 1100: half [15:0] / [31:16].
  - 1111: the full word.
  - Any other pattern: 0.
- Extension: byte and halfword are sign-extended when sx=1, zero-extended otherwise.
- Outputs:
  - reg_write_data = rd ? extracted value : result.
  - reg_write_en = we.
  - reg_write_addr = waddr.
  - A write to register 0 is passed through; the register file ignores it.
- A store (wr=1, rd=0) writes back only if we=1, which it normally does not.

## Timing
- Reset: all WB fields 0, ld_hold=0, ld_valid=0. Therefore reg_write_en=0, reg_write_addr=0, reg_write_data=0.
- Latency: MEM inputs appear on outputs 1 cycle later (registered).
- Load data path is combinational from ram_read_data to reg_write_data in the first WB cycle.
- During a stall, outputs are constant cycle-to-cycle, including load data, even if ram_read_data changes after the first stalled edge.
- The first WB cycle of a stalled load uses live ram_read_data; that same value is what gets latched.
- Stall deasserting: the next edge loads new contents and clears ld_valid.
- Reset asserted mid-operation: immediate clear, no edge required; the in-flight instruction is lost.

## Configuration
- `MEM_WB_DEBUG_TRACE_EN`
  - Defined: adds outputs debug_pc (ADDR_W) = pc, debug_wen (1) = we & ~stall, debug_wdata (DATA_W) = reg_write_data, debug_waddr (REG_AW) = waddr, for the commit-trace comparator. Reset value of all four is 0.
  - Undefined: these ports and their logic are absent. Core behaviour is identical.

## Test plan
- Reset: assert rst mid-cycle with we=1 loaded → all outputs 0 immediately. After release with idle inputs, outputs stay 0.
- ALU passthrough: result_in=0x1234_5678, we=1, waddr=5, rd=0 → next cycle reg_write_en=1, reg_write_addr=5, reg_write_data=0x1234_5678.
- Byte/half loads with ram_read_data=0x80FF_7F81:
  - sel=0001, sx=1 → 0xFFFF_FF81.
  - sel=1000, sx=0 → 0x0000_0080.
  - sel=1100, sx=1 → 0xFFFF_80FF.
  - sel=0011, sx=0 → 0x0000_7F81.
  - sel=0101 → 0.
- Stalled load: lw sel=1111 enters WB with ram_read_data=0xDEAD_BEEF, stall=1 for 3 cycles, ram_read_data changes to 0x0 after the first edge → reg_write_data stays 0xDEAD_BEEF for all 4 WB cycles.
- Flush vs stall: stall=1 and flush=1 on the same edge with a valid instruction in WB → next cycle reg_write_en=0, reg_write_data=0.
- Back-to-back loads without stall: ram data 0x11 then 0x22 on consecutive cycles, sel=0001 → outputs 0x11 then 0x22, ld_valid never set.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus write-back data selection.
// Captures MEM-stage control/result fields, merges synchronous RAM load data,
// extracts and extends the addressed byte/halfword, and drives the register
// file write port (which doubles as the WB forwarding path back to ID).
// Optional feature macro: MEM_WB_DEBUG_TRACE_EN adds commit-trace outputs.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_read_flag_in,
  input  logic              mem_write_flag_in,
  input  logic              mem_sign_ext_flag_in,
  input  logic [SEL_W-1:0]  mem_sel_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic              reg_write_en_in,
  input  logic [REG_AW-1:0] reg_write_addr_in,
  input  logic [ADDR_W-1:0] current_pc_addr_in,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              reg_write_en,
  output logic [REG_AW-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_write_data
`ifdef MEM_WB_DEBUG_TRACE_EN
  ,
  output logic [ADDR_W-1:0] debug_pc,
  output logic              debug_wen,
  output logic [DATA_W-1:0] debug_wdata,
  output logic [REG_AW-1:0] debug_waddr
`endif
);

  // WB register fields
  logic              wb_rd;
  logic              wb_wr;
  logic              wb_sx;
  logic [SEL_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_result;
  logic              wb_we;
  logic [REG_AW-1:0] wb_waddr;
  logic [ADDR_W-1:0] wb_pc;

  // Load data captured on the first stalled edge so a long stall keeps
  // presenting the word the RAM returned in the first WB cycle.
  logic [DATA_W-1:0] ld_hold;
  logic              ld_valid;

  logic [DATA_W-1:0] lw_raw;
  logic [DATA_W-1:0] ext_val;

  // The store flag and (without tracing) the PC ride along but feed nothing.
  logic unused_fields;
  assign unused_fields = ^{wb_wr, wb_pc};

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sx);
    ext_byte = {{(DATA_W-8){sx & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sx);
    ext_half = {{(DATA_W-16){sx & h[15]}}, h};
  endfunction

  // Pipeline register: flush beats stall, stall holds, otherwise capture MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd     <= 1'b0;
      wb_wr     <= 1'b0;
      wb_sx     <= 1'b0;
      wb_sel    <= '0;
      wb_result <= '0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_pc     <= '0;
    end else if (flush) begin
      wb_rd     <= 1'b0;
      wb_wr     <= 1'b0;
      wb_sx     <= 1'b0;
      wb_sel    <= '0;
      wb_result <= '0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_pc     <= '0;
    end else if (!stall) begin
      wb_rd     <= mem_read_flag_in;
      wb_wr     <= mem_write_flag_in;
      wb_sx     <= mem_sign_ext_flag_in;
      wb_sel    <= mem_sel_in;
      wb_result <= result_in;
      wb_we     <= reg_write_en_in;
      wb_waddr  <= reg_write_addr_in;
      wb_pc     <= current_pc_addr_in;
    end
  end

  // Latch the live RAM word once when a load first stalls; any new WB
  // contents (load or flush) invalidate the held copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_hold  <= '0;
      ld_valid <= 1'b0;
    end else if (flush || !stall) begin
      ld_valid <= 1'b0;
    end else if (wb_rd && !ld_valid) begin
      ld_hold  <= ram_read_data;
      ld_valid <= 1'b1;
    end
  end

  assign lw_raw = ld_valid ? ld_hold : ram_read_data;

  // Little-endian lane extraction with sign or zero extension.
  always_comb begin
    ext_val = '0;
    case (wb_sel)
      4'b0001: ext_val = ext_byte(lw_raw[7:0],   wb_sx);
      4'b0010: ext_val = ext_byte(lw_raw[15:8],  wb_sx);
      4'b0100: ext_val = ext_byte(lw_raw[23:16], wb_sx);
      4'b1000: ext_val = ext_byte(lw_raw[31:24], wb_sx);
      4'b0011: ext_val = ext_half(lw_raw[15:0],  wb_sx);
      4'b1100: ext_val = ext_half(lw_raw[31:16], wb_sx);
      4'b1111: ext_val = lw_raw;
      default: ext_val = '0;
    endcase
  end

  assign reg_write_data = wb_rd ? ext_val : wb_result;
  assign reg_write_en   = wb_we;
  assign reg_write_addr = wb_waddr;

`ifdef MEM_WB_DEBUG_TRACE_EN
  // A stalled instruction is reported to the trace only on its final WB cycle.
  assign debug_pc    = wb_pc;
  assign debug_wen   = wb_we & ~stall;
  assign debug_wdata = reg_write_data;
  assign debug_waddr = wb_waddr;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed plus randomized checks of mem_wb_stage against
// a behavioural model of the write-back stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        mem_read_flag_in = 1'b0;
  logic        mem_write_flag_in = 1'b0;
  logic        mem_sign_ext_flag_in = 1'b0;
  logic [3:0]  mem_sel_in = '0;
  logic [31:0] result_in = '0;
  logic        reg_write_en_in = 1'b0;
  logic [4:0]  reg_write_addr_in = '0;
  logic [31:0] current_pc_addr_in = '0;
  logic [31:0] ram_read_data = '0;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
`ifdef MEM_WB_DEBUG_TRACE_EN
  logic [31:0] debug_pc;
  logic        debug_wen;
  logic [31:0] debug_wdata;
  logic [4:0]  debug_waddr;
`endif

  int total = 0;
  int bad = 0;

  // Model: the instruction currently in WB, how many edges it has been
  // stalled there, and the RAM word it saw in its first WB cycle.
  typedef struct {
    bit          rd;
    bit          sx;
    logic [3:0]  sel;
    logic [31:0] result;
    bit          we;
    logic [4:0]  waddr;
  } wb_t;

  wb_t         m_wb;
  int          m_age;
  logic [31:0] m_first;

  mem_wb_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .flush                (flush),
    .mem_read_flag_in     (mem_read_flag_in),
    .mem_write_flag_in    (mem_write_flag_in),
    .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
    .mem_sel_in           (mem_sel_in),
    .result_in            (result_in),
    .reg_write_en_in      (reg_write_en_in),
    .reg_write_addr_in    (reg_write_addr_in),
    .current_pc_addr_in   (current_pc_addr_in),
    .ram_read_data        (ram_read_data),
    .reg_write_en         (reg_write_en),
    .reg_write_addr       (reg_write_addr),
    .reg_write_data       (reg_write_data)
`ifdef MEM_WB_DEBUG_TRACE_EN
    ,
    .debug_pc             (debug_pc),
    .debug_wen            (debug_wen),
    .debug_wdata          (debug_wdata),
    .debug_waddr          (debug_waddr)
`endif
  );

  always #5 clk = ~clk;

  // Load value = the selected lanes of the word, shifted down and extended.
  function automatic logic [31:0] model_extract(input logic [31:0] w, input logic [3:0] sel,
                                                input bit sx);
    int lo;
    int n;
    logic [31:0] mask;
    logic [31:0] v;
    lo = 0;
    n = 0;
    case (sel)
      4'd1:  begin lo = 0;  n = 8;  end
      4'd2:  begin lo = 8;  n = 8;  end
      4'd4:  begin lo = 16; n = 8;  end
      4'd8:  begin lo = 24; n = 8;  end
      4'd3:  begin lo = 0;  n = 16; end
      4'd12: begin lo = 16; n = 16; end
      4'd15: begin lo = 0;  n = 32; end
      default: n = 0;
    endcase
    if (n == 0) return 32'h0;
    if (n == 32) return w;
    mask = (32'h1 << n) - 32'h1;
    v = (w >> lo) & mask;
    if (sx && v[n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_reset();
    m_wb    = '{rd: 1'b0, sx: 1'b0, sel: 4'h0, result: 32'h0, we: 1'b0, waddr: 5'h0};
    m_age   = 0;
    m_first = 32'h0;
  endtask

  task automatic applyStimulus(input bit s, input bit f, input bit rd, input bit wr,
                               input bit sx, input logic [3:0] sel, input logic [31:0] res,
                               input bit we, input logic [4:0] wa, input logic [31:0] ram);
    @(negedge clk);
    stall                = s;
    flush                = f;
    mem_read_flag_in     = rd;
    mem_write_flag_in    = wr;
    mem_sign_ext_flag_in = sx;
    mem_sel_in           = sel;
    result_in            = res;
    reg_write_en_in      = we;
    reg_write_addr_in    = wa;
    current_pc_addr_in   = $urandom;
    ram_read_data        = ram;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_en, input logic [4:0] exp_addr,
                             input logic [31:0] exp_data);
    total++;
    assert (reg_write_en === exp_en && reg_write_addr === exp_addr && reg_write_data === exp_data)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed en=%0b addr=%0d data=%h, expected en=%0b addr=%0d data=%h",
             tag, reg_write_en, reg_write_addr, reg_write_data, exp_en, exp_addr, exp_data);
    end
  endtask

  task automatic modelCheck(input string tag);
    logic [31:0] d;
    if (m_wb.rd) d = model_extract((m_age == 0) ? ram_read_data : m_first, m_wb.sel, m_wb.sx);
    else         d = m_wb.result;
    checkOutput(tag, m_wb.we, m_wb.waddr, d);
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic clockEdge();
    @(posedge clk);
    if (rst || flush) begin
      model_reset();
    end else if (stall) begin
      if (m_age == 0) m_first = ram_read_data;
      m_age++;
    end else begin
      m_wb = '{rd: mem_read_flag_in, sx: mem_sign_ext_flag_in, sel: mem_sel_in,
               result: result_in, we: reg_write_en_in, waddr: reg_write_addr_in};
      m_age = 0;
    end
  endtask

  initial begin
    logic [3:0]  sel_tab [0:4];
    bit          sx_tab  [0:4];
    logic [31:0] exp_tab [0:4];
    logic [3:0]  rsel_tab [0:9];
    string       tag;

    sel_tab = '{4'b0001, 4'b1000, 4'b1100, 4'b0011, 4'b0101};
    sx_tab  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_tab = '{32'hFFFF_FF81, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F81, 32'h0};
    rsel_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15, 4'd5, 4'd0, 4'd15};
    model_reset();

    // Reset state
    #1;
    checkOutput("reset_state", 1'b0, 5'd0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    rst = 1'b0;
    clockEdge();

    // ALU passthrough
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h1234_5678, 1, 5'd5, 32'h0);
    modelCheck("pre_pass");
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("alu_pass", 1'b1, 5'd5, 32'h1234_5678);
    modelCheck("alu_pass_model");
    clockEdge();

    // Byte / halfword extraction on a fixed RAM word
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, sx_tab[i], sel_tab[i], 32'hAAAA_AAAA, 1, 5'd3, 32'h0);
      clockEdge();
      applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h80FF_7F81);
      tag = $sformatf("load_sel%b", sel_tab[i]);
      checkOutput(tag, 1'b1, 5'd3, exp_tab[i]);
      clockEdge();
    end

    // Stalled word load: RAM changes after the first stalled edge
    applyStimulus(0, 0, 1, 0, 0, 4'hF, 32'h0, 1, 5'd7, 32'h0);
    clockEdge();
    applyStimulus(1, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'hDEAD_BEEF);
    checkOutput("stall_ld_c1", 1'b1, 5'd7, 32'hDEAD_BEEF);
    clockEdge();
    applyStimulus(1, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("stall_ld_c2", 1'b1, 5'd7, 32'hDEAD_BEEF);
    clockEdge();
    applyStimulus(1, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("stall_ld_c3", 1'b1, 5'd7, 32'hDEAD_BEEF);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("stall_ld_c4", 1'b1, 5'd7, 32'hDEAD_BEEF);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("after_stall", 1'b0, 5'd0, 32'h0);
    clockEdge();

    // Flush wins over stall
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'hCAFE_F00D, 1, 5'd12, 32'h0);
    clockEdge();
    applyStimulus(1, 1, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("pre_flush", 1'b1, 5'd12, 32'hCAFE_F00D);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("flush_stall", 1'b0, 5'd0, 32'h0);
    clockEdge();

    // Back-to-back byte loads without stall
    applyStimulus(0, 0, 1, 0, 0, 4'h1, 32'h0, 1, 5'd9, 32'h0);
    clockEdge();
    applyStimulus(0, 0, 1, 0, 0, 4'h1, 32'h0, 1, 5'd10, 32'h11);
    checkOutput("b2b_first", 1'b1, 5'd9, 32'h11);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h22);
    checkOutput("b2b_second", 1'b1, 5'd10, 32'h22);
    clockEdge();

    // Asynchronous reset mid-cycle with a write in WB
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h5555_AAAA, 1, 5'd21, 32'h0);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("pre_reset", 1'b1, 5'd21, 32'h5555_AAAA);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    checkOutput("async_reset", 1'b0, 5'd0, 32'h0);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_idle1", 1'b0, 5'd0, 32'h0);
    clockEdge();
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 5'd0, 32'h0);
    checkOutput("post_reset_idle2", 1'b0, 5'd0, 32'h0);
    clockEdge();

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    (i % 7 == 6) ? 4'($urandom) : rsel_tab[$urandom_range(0, 9)],
                    $urandom, 1'($urandom), 5'($urandom), $urandom);
      tag = $sformatf("rand_%0d", i);
      modelCheck(tag);
      clockEdge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
